// File: rtl/data_memory_if.sv
// ---------------------------------------------------------------------------
// data_memory_if
//   Bundle of the core's data-memory bus: one word-indexed read port and one
//   independent word-indexed write port with a store-width code.
//
//   Signals
//     rd_addr0 [AW-1:0]  read word index                 (core -> memory)
//     wr_addr0 [AW-1:0]  write word index                (core -> memory)
//     wr_din0  [31:0]    write data, right-aligned       (core -> memory)
//     we0                write enable                    (core -> memory)
//     wr_strb  [2:0]     store width: 000 SB, 001 SH, 010 SW (core -> memory)
//     rd_dout0 [31:0]    registered read data            (memory -> core)
//
//   Modports
//     master : the core side (drives addresses, data, enables)
//     slave  : the memory side
//     memory : alias of slave, the name used by the core's port list
// ---------------------------------------------------------------------------
interface data_memory_if #(
  parameter int MEM_DEPTH = 4
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [AW-1:0] rd_addr0;
  logic [AW-1:0] wr_addr0;
  logic [31:0]   wr_din0;
  logic          we0;
  logic [2:0]    wr_strb;
  logic [31:0]   rd_dout0;

  modport master (
    output rd_addr0,
    output wr_addr0,
    output wr_din0,
    output we0,
    output wr_strb,
    input  rd_dout0
  );

  modport slave (
    input  rd_addr0,
    input  wr_addr0,
    input  wr_din0,
    input  we0,
    input  wr_strb,
    output rd_dout0
  );

  modport memory (
    input  rd_addr0,
    input  wr_addr0,
    input  wr_din0,
    input  we0,
    input  wr_strb,
    output rd_dout0
  );
endinterface

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//   Word-organised synchronous data RAM for the RISC-V core. One read port,
//   one independent write port, byte/halfword/word stores, registered read
//   data (one cycle latency, read-first on a same-address collision).
//
//   Ports
//     clk      : clock, all state changes on the rising edge
//     rst      : synchronous active-high reset; clears every word and the
//                read register, and drops any write in the same cycle
//     mem_bus  : data_memory_if slave side (rd_addr0, wr_addr0, wr_din0,
//                we0, wr_strb in; rd_dout0 out)
//
//   Parameter
//     MEM_DEPTH : number of 32-bit words, power of two, >= 2
// ---------------------------------------------------------------------------
module data_memory #(
  parameter int MEM_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  data_memory_if.slave mem_bus
);
  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [2:0] STRB_SB = 3'b000;
  localparam logic [2:0] STRB_SH = 3'b001;
  localparam logic [2:0] STRB_SW = 3'b010;

  // Byte lanes touched by the current store. Write data is right-aligned, so
  // lane b always takes wr_din0[8b+7:8b]; the width code only decides how
  // many low lanes are enabled. Reserved codes enable nothing.
  logic [3:0] lane_en;

  always_comb begin
    lane_en = 4'b0000;
    if (mem_bus.we0) begin
      case (mem_bus.wr_strb)
        STRB_SB: lane_en = 4'b0001;
        STRB_SH: lane_en = 4'b0011;
        STRB_SW: lane_en = 4'b1111;
        default: lane_en = 4'b0000;
      endcase
    end
  end

  // Current contents of every word, gathered for the read mux.
  logic [31:0] mem_words [MEM_DEPTH];

  // Each word is its own register with a resettable clear; the whole array
  // must read back as zero right after reset, which a plain RAM macro cannot
  // provide.
  genvar gi;
  generate
    for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
      logic        word_sel;
      logic [31:0] word_d;
      logic [31:0] word_q;

      assign word_sel = (mem_bus.wr_addr0 == AW'(gi));

      always_comb begin
        word_d = word_q;
        if (word_sel) begin
          for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) begin
              word_d[8*b +: 8] = mem_bus.wr_din0[8*b +: 8];
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          word_q <= 32'h0000_0000;
        end else begin
          word_q <= word_d;
        end
      end

      assign mem_words[gi] = word_q;
    end
  endgenerate

  // Read register samples the pre-edge word contents, so a write to the same
  // address in the same cycle is not seen until the next read (read-first).
  logic [31:0] rd_dout_d;
  logic [31:0] rd_dout_q;

  always_comb begin
    rd_dout_d = mem_words[mem_bus.rd_addr0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dout_q <= 32'h0000_0000;
    end else begin
      rd_dout_q <= rd_dout_d;
    end
  end

  assign mem_bus.rd_dout0 = rd_dout_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  data_memory_if #(.MEM_DEPTH(DEPTH)) bus ();

  data_memory #(.MEM_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: memory as a plain array of words, expected read value as the
  // word seen before this edge's store.
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q;
  logic        exp_valid = 1'b0;

  function automatic logic [31:0] merge_store(input logic [31:0] old_w,
                                              input logic [31:0] din,
                                              input logic [2:0]  strb);
    case (strb)
      3'b000:  return (old_w & 32'hFFFF_FF00) | (din & 32'h0000_00FF);
      3'b001:  return (old_w & 32'hFFFF_0000) | (din & 32'h0000_FFFF);
      3'b010:  return din;
      default: return old_w;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model[i] <= 32'h0;
      exp_q     <= 32'h0;
      exp_valid <= 1'b1;
    end else begin
      exp_q <= model[bus.rd_addr0];
      if (bus.we0)
        model[bus.wr_addr0] <= merge_store(model[bus.wr_addr0], bus.wr_din0, bus.wr_strb);
    end
  end

  // Every-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_valid) begin
        total++;
        if (bus.rd_dout0 !== exp_q) begin
          bad++;
          $display("FAIL cycle_compare cyc=%0d got=%08h want=%08h", cyc, bus.rd_dout0, exp_q);
        end
      end
    end
  end

  // One transaction per clock: drive, take the edge, settle just after it.
  task automatic step(input logic r, input logic w, input logic [1:0] wa,
                      input logic [31:0] d, input logic [2:0] s,
                      input logic [1:0] ra);
    rst          = r;
    bus.we0      = w;
    bus.wr_addr0 = wa;
    bus.wr_din0  = d;
    bus.wr_strb  = s;
    bus.rd_addr0 = ra;
    @(posedge clk);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [31:0] want);
    total++;
    if (bus.rd_dout0 !== want) begin
      bad++;
      $display("FAIL %s dut got=%08h want=%08h", name, bus.rd_dout0, want);
    end else begin
      $display("txn %s rd_dout0=%08h ok", name, bus.rd_dout0);
    end
    total++;
    if (exp_q !== want) begin
      bad++;
      $display("FAIL %s model got=%08h want=%08h", name, exp_q, want);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.we0 = 1'b0; bus.wr_addr0 = '0; bus.wr_din0 = '0;
    bus.wr_strb = 3'b010; bus.rd_addr0 = '0;
    #2;

    // Garbage, then a single reset edge.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 2'(i), $urandom, 3'b010, 2'(i));
    step(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 3'b010, 2'd0);
    check_lit("reset_dout", 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 2'd0, 32'h0, 3'b010, 2'(i));
      check_lit($sformatf("reset_word%0d", i), 32'h0);
    end

    // Word write then read.
    step(1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 3'b010, 2'd0);
    step(1'b0, 1'b0, 2'd0, 32'h0, 3'b010, 2'd2);
    check_lit("sw_read", 32'hDEADBEEF);

    // Partial stores.
    step(1'b0, 1'b1, 2'd1, 32'h11223344, 3'b010, 2'd0);
    step(1'b0, 1'b1, 2'd1, 32'hFFFF_FFAA, 3'b000, 2'd0);
    step(1'b0, 1'b0, 2'd0, 32'h0, 3'b010, 2'd1);
    check_lit("sb_merge", 32'h112233AA);
    step(1'b0, 1'b1, 2'd1, 32'h0000_BEEF, 3'b001, 2'd0);
    step(1'b0, 1'b0, 2'd0, 32'h0, 3'b010, 2'd1);
    check_lit("sh_merge", 32'h1122BEEF);

    // Reserved width code and we0=0 both leave the word alone.
    step(1'b0, 1'b1, 2'd3, 32'h12345678, 3'b010, 2'd0);
    step(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 3'b111, 2'd0);
    step(1'b0, 1'b0, 2'd0, 32'h0, 3'b010, 2'd3);
    check_lit("reserved_strb", 32'h12345678);
    step(1'b0, 1'b0, 2'd3, 32'h0, 3'b010, 2'd0);
    step(1'b0, 1'b0, 2'd0, 32'h0, 3'b010, 2'd3);
    check_lit("we0_low", 32'h12345678);

    // Same-address collision is read-first.
    step(1'b0, 1'b1, 2'd0, 32'hA5A5A5A5, 3'b010, 2'd1);
    step(1'b0, 1'b1, 2'd0, 32'h5A5A5A5A, 3'b010, 2'd0);
    check_lit("collide_old", 32'hA5A5A5A5);
    step(1'b0, 1'b0, 2'd0, 32'h0, 3'b010, 2'd0);
    check_lit("collide_new", 32'h5A5A5A5A);

    // Independent ports on different addresses in one cycle.
    step(1'b0, 1'b1, 2'd2, 32'h0BAD_F00D, 3'b010, 2'd3);
    check_lit("diff_addr_read", 32'h12345678);
    step(1'b0, 1'b0, 2'd0, 32'h0, 3'b010, 2'd2);
    check_lit("diff_addr_write", 32'h0BAD_F00D);

    // Reset in the same cycle as a store drops the store.
    step(1'b1, 1'b1, 2'd1, 32'hCAFEBABE, 3'b010, 2'd1);
    check_lit("rst_mid_dout", 32'h0);
    step(1'b0, 1'b0, 2'd0, 32'h0, 3'b010, 2'd1);
    check_lit("rst_mid_word", 32'h0);

    // Random traffic, checked every cycle by the compare process.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, DEPTH - 1)), $urandom,
           3'($urandom_range(0, 7)), 2'($urandom_range(0, DEPTH - 1)));
    end
    step(1'b0, 1'b0, 2'd0, 32'h0, 3'b010, 2'd0);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
